// File: rtl/control_unit.sv
// RV32 integer main decoder: opcode/funct3/funct7 -> registered datapath controls.
// All outputs are registered, so a decode appears one clock after its inputs are sampled.
module control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       reg_write,
    output logic       alu_src,
    output logic [2:0] alu_ctrl,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       branch,
    output logic       branch_ne,
    output logic       illegal
);

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_I      = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLT = 3'b111
    } alu_e;

    logic       w_reg_write;
    logic       w_alu_src;
    alu_e       w_alu_ctrl;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_mem_to_reg;
    logic       w_branch;
    logic       w_branch_ne;
    logic       w_illegal;

    logic       r_reg_write;
    logic       r_alu_src;
    logic [2:0] r_alu_ctrl;
    logic       r_mem_read;
    logic       r_mem_write;
    logic       r_mem_to_reg;
    logic       r_branch;
    logic       r_branch_ne;
    logic       r_illegal;

    always_comb begin
        w_reg_write  = 1'b0;
        w_alu_src    = 1'b0;
        w_alu_ctrl   = ALU_ADD;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_branch     = 1'b0;
        w_branch_ne  = 1'b0;
        w_illegal    = 1'b0;

        case (opcode)
            OP_R: begin
                w_reg_write = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: w_alu_ctrl = ALU_ADD;
                    {7'b0100000, 3'b000}: w_alu_ctrl = ALU_SUB;
                    {7'b0000000, 3'b111}: w_alu_ctrl = ALU_AND;
                    {7'b0000000, 3'b110}: w_alu_ctrl = ALU_OR;
                    {7'b0000000, 3'b100}: w_alu_ctrl = ALU_XOR;
                    {7'b0000000, 3'b001}: w_alu_ctrl = ALU_SLL;
                    {7'b0000000, 3'b101}: w_alu_ctrl = ALU_SRL;
                    {7'b0000000, 3'b010}: w_alu_ctrl = ALU_SLT;
                    default:              w_illegal  = 1'b1;
                endcase
            end
            OP_I: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
                case (funct3)
                    3'b000:  w_alu_ctrl = ALU_ADD;
                    3'b111:  w_alu_ctrl = ALU_AND;
                    3'b110:  w_alu_ctrl = ALU_OR;
                    3'b100:  w_alu_ctrl = ALU_XOR;
                    3'b010:  w_alu_ctrl = ALU_SLT;
                    3'b001: begin
                        w_alu_ctrl = ALU_SLL;
                        w_illegal  = (funct7 != 7'b0000000);
                    end
                    3'b101: begin
                        w_alu_ctrl = ALU_SRL;
                        w_illegal  = (funct7 != 7'b0000000);
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_mem_read   = 1'b1;
                w_mem_to_reg = 1'b1;
                w_illegal    = (funct3 != 3'b010);
            end
            OP_STORE: begin
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
                w_illegal   = (funct3 != 3'b010);
            end
            OP_BRANCH: begin
                w_alu_ctrl  = ALU_SUB;
                w_branch    = 1'b1;
                w_branch_ne = (funct3 == 3'b001);
                w_illegal   = (funct3[2:1] != 2'b00);
            end
            default: w_illegal = 1'b1;
        endcase

        // Each opcode arm sets its controls before validating funct fields;
        // an illegal decode wipes them so only the flag survives.
        if (w_illegal) begin
            w_reg_write  = 1'b0;
            w_alu_src    = 1'b0;
            w_alu_ctrl   = ALU_ADD;
            w_mem_read   = 1'b0;
            w_mem_write  = 1'b0;
            w_mem_to_reg = 1'b0;
            w_branch     = 1'b0;
            w_branch_ne  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_write  <= 1'b0;
            r_alu_src    <= 1'b0;
            r_alu_ctrl   <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_branch     <= 1'b0;
            r_branch_ne  <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_reg_write  <= w_reg_write;
            r_alu_src    <= w_alu_src;
            r_alu_ctrl   <= w_alu_ctrl;
            r_mem_read   <= w_mem_read;
            r_mem_write  <= w_mem_write;
            r_mem_to_reg <= w_mem_to_reg;
            r_branch     <= w_branch;
            r_branch_ne  <= w_branch_ne;
            r_illegal    <= w_illegal;
        end
    end

    assign reg_write  = r_reg_write;
    assign alu_src    = r_alu_src;
    assign alu_ctrl   = r_alu_ctrl;
    assign mem_read   = r_mem_read;
    assign mem_write  = r_mem_write;
    assign mem_to_reg = r_mem_to_reg;
    assign branch     = r_branch;
    assign branch_ne  = r_branch_ne;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed steps plus random instructions checked
// against a table of supported instructions (anything unmatched is illegal).
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       reg_write;
    logic       alu_src;
    logic [2:0] alu_ctrl;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       branch_ne;
    logic       illegal;

    int unsigned checks = 0;
    int unsigned errors = 0;

    control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .reg_write  (reg_write),
        .alu_src    (alu_src),
        .alu_ctrl   (alu_ctrl),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .branch     (branch),
        .branch_ne  (branch_ne),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector layout: {reg_write, alu_src, alu_ctrl[2:0], mem_read,
    //                        mem_write, mem_to_reg, branch, branch_ne, illegal}
    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7_care;
        logic [6:0]  f7;
        logic [10:0] res;
    } entry_t;

    entry_t tbl[$];

    localparam logic [10:0] ILLEGAL_VEC = 11'b000_0000_0001;

    function automatic logic [10:0] vec(input logic rw, input logic src, input logic [2:0] alu,
                                        input logic mr, input logic mw, input logic m2r,
                                        input logic br, input logic bne);
        return {rw, src, alu, mr, mw, m2r, br, bne, 1'b0};
    endfunction

    task automatic add_entry(input logic [6:0] op, input logic [2:0] f3, input logic care,
                             input logic [6:0] f7, input logic [10:0] res);
        entry_t e;
        e.op = op; e.f3 = f3; e.f7_care = care; e.f7 = f7; e.res = res;
        tbl.push_back(e);
    endtask

    task automatic build_table();
        // R-type: exact funct7
        add_entry(7'b0110011, 3'b000, 1'b1, 7'h00, vec(1, 0, 3'd0, 0, 0, 0, 0, 0));
        add_entry(7'b0110011, 3'b000, 1'b1, 7'h20, vec(1, 0, 3'd1, 0, 0, 0, 0, 0));
        add_entry(7'b0110011, 3'b111, 1'b1, 7'h00, vec(1, 0, 3'd2, 0, 0, 0, 0, 0));
        add_entry(7'b0110011, 3'b110, 1'b1, 7'h00, vec(1, 0, 3'd3, 0, 0, 0, 0, 0));
        add_entry(7'b0110011, 3'b100, 1'b1, 7'h00, vec(1, 0, 3'd4, 0, 0, 0, 0, 0));
        add_entry(7'b0110011, 3'b001, 1'b1, 7'h00, vec(1, 0, 3'd5, 0, 0, 0, 0, 0));
        add_entry(7'b0110011, 3'b101, 1'b1, 7'h00, vec(1, 0, 3'd6, 0, 0, 0, 0, 0));
        add_entry(7'b0110011, 3'b010, 1'b1, 7'h00, vec(1, 0, 3'd7, 0, 0, 0, 0, 0));
        // I-type ALU: funct7 ignored except for shifts
        add_entry(7'b0010011, 3'b000, 1'b0, 7'h00, vec(1, 1, 3'd0, 0, 0, 0, 0, 0));
        add_entry(7'b0010011, 3'b111, 1'b0, 7'h00, vec(1, 1, 3'd2, 0, 0, 0, 0, 0));
        add_entry(7'b0010011, 3'b110, 1'b0, 7'h00, vec(1, 1, 3'd3, 0, 0, 0, 0, 0));
        add_entry(7'b0010011, 3'b100, 1'b0, 7'h00, vec(1, 1, 3'd4, 0, 0, 0, 0, 0));
        add_entry(7'b0010011, 3'b010, 1'b0, 7'h00, vec(1, 1, 3'd7, 0, 0, 0, 0, 0));
        add_entry(7'b0010011, 3'b001, 1'b1, 7'h00, vec(1, 1, 3'd5, 0, 0, 0, 0, 0));
        add_entry(7'b0010011, 3'b101, 1'b1, 7'h00, vec(1, 1, 3'd6, 0, 0, 0, 0, 0));
        // LW, SW, BEQ, BNE
        add_entry(7'b0000011, 3'b010, 1'b0, 7'h00, vec(1, 1, 3'd0, 1, 0, 1, 0, 0));
        add_entry(7'b0100011, 3'b010, 1'b0, 7'h00, vec(0, 1, 3'd0, 0, 1, 0, 0, 0));
        add_entry(7'b1100011, 3'b000, 1'b0, 7'h00, vec(0, 0, 3'd1, 0, 0, 0, 1, 0));
        add_entry(7'b1100011, 3'b001, 1'b0, 7'h00, vec(0, 0, 3'd1, 0, 0, 0, 1, 1));
    endtask

    function automatic logic [10:0] model(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7);
        foreach (tbl[i]) begin
            if (tbl[i].op == op && tbl[i].f3 == f3 && (!tbl[i].f7_care || tbl[i].f7 == f7))
                return tbl[i].res;
        end
        return ILLEGAL_VEC;
    endfunction

    function automatic logic [10:0] observed();
        return {reg_write, alu_src, alu_ctrl, mem_read, mem_write, mem_to_reg,
                branch, branch_ne, illegal};
    endfunction

    task automatic check(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op; funct3 = f3; funct7 = f7;
    endtask

    // Apply inputs on the falling edge, check one rising edge later.
    task automatic step(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7);
        @(negedge clk);
        drive(op, f3, f7);
        @(posedge clk);
        #1;
        check(tag, model(op, f3, f7));
    endtask

    logic [6:0]  r_op;
    logic [2:0]  r_f3;
    logic [6:0]  r_f7;
    logic [10:0] held;
    logic [6:0]  ops [6];

    initial begin
        build_table();
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1111111;

        rst_n = 1'b0;
        drive(7'b0110011, 3'b000, 7'h00);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 11'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("add_after_release", vec(1, 0, 3'd0, 0, 0, 0, 0, 0));

        // Asynchronous reset mid-cycle clears outputs without any edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 11'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("add_after_async", vec(1, 0, 3'd0, 0, 0, 0, 0, 0));

        step("r_add",  7'b0110011, 3'b000, 7'h00);
        step("r_sub",  7'b0110011, 3'b000, 7'h20);
        step("r_and",  7'b0110011, 3'b111, 7'h00);
        step("r_or",   7'b0110011, 3'b110, 7'h00);
        step("r_xor",  7'b0110011, 3'b100, 7'h00);
        step("r_sll",  7'b0110011, 3'b001, 7'h00);
        step("r_srl",  7'b0110011, 3'b101, 7'h00);
        step("r_slt",  7'b0110011, 3'b010, 7'h00);
        step("r_sltu", 7'b0110011, 3'b011, 7'h00);
        step("r_sra",  7'b0110011, 3'b101, 7'h20);
        step("r_andf7", 7'b0110011, 3'b111, 7'h20);
        step("addi",   7'b0010011, 3'b000, 7'h00);
        step("addi_f7", 7'b0010011, 3'b000, 7'h20);
        step("srli_f7", 7'b0010011, 3'b101, 7'h20);
        step("slli",   7'b0010011, 3'b001, 7'h00);
        step("sltiu",  7'b0010011, 3'b011, 7'h00);
        step("lw",     7'b0000011, 3'b010, 7'h00);
        step("lb",     7'b0000011, 3'b000, 7'h00);
        step("sw",     7'b0100011, 3'b010, 7'h00);
        step("sh",     7'b0100011, 3'b001, 7'h00);
        step("beq",    7'b1100011, 3'b000, 7'h00);
        step("bne",    7'b1100011, 3'b001, 7'h00);
        step("blt",    7'b1100011, 3'b100, 7'h00);
        step("op_ff",  7'b1111111, 3'b000, 7'h00);

        // Outputs hold when inputs change between edges
        step("hold_pre", 7'b0000011, 3'b010, 7'h00);
        held = model(7'b0000011, 3'b010, 7'h00);
        @(negedge clk);
        drive(7'b1100011, 3'b001, 7'h00);
        #3;
        check("hold_mid", held);
        @(posedge clk);
        #1;
        check("hold_next", model(7'b1100011, 3'b001, 7'h00));

        for (int n = 0; n < 400; n++) begin
            r_op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
            r_f3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0, 1:    r_f7 = 7'h00;
                2:       r_f7 = 7'h20;
                default: r_f7 = 7'($urandom);
            endcase
            step("random", r_op, r_f3, r_f7);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Main decoder of the single-issue RV32 integer pipeline, placed between the instruction register and the register file, ALU and data-memory datapath. It decodes opcode, funct3 and funct7 into datapath control signals: register-write enable, ALU operand select, 3-bit ALU operation, memory and branch controls, and an illegal-instruction flag. All outputs are registered, giving one clock of latency.

Parameters:
None.

Ports:
clk  input  1  system clock; outputs update on the rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  7  instruction bits [6:0]
funct3  input  3  instruction bits [14:12]
funct7  input  7  instruction bits [31:25]
reg_write  output  1  write rd in the register file
alu_src  output  1  0 = ALU operand B from rs2; 1 = from immediate
alu_ctrl  output  3  ALU operation (encoding below)
mem_read  output  1  data-memory load enable
mem_write  output  1  data-memory store enable
mem_to_reg  output  1  writeback source: 1 = memory data, 0 = ALU result
branch  output  1  conditional-branch instruction
branch_ne  output  1  1 = BNE, 0 = BEQ; valid only when branch=1
illegal  output  1  instruction not supported

Behaviour:
- Clock and reset: one clock (clk); asynchronous active-low reset (rst_n).
- Reset: while rst_n=0, every output is 0 immediately, with no clock edge needed. Deassertion takes effect at the next rising edge.
- Timing: a combinational decode feeds output registers. The inputs present at rising edge N appear on the outputs after edge N and hold until edge N+1. There is no enable and no handshake; the unit decodes every cycle.
- alu_ctrl encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SLT.
- Default for every case below: all outputs 0 unless listed.
- R-type (opcode 0110011): reg_write=1, alu_src=0. Decode by funct3/funct7:
  - 000/0000000 ADD; 000/0100000 SUB
  - 111/0000000 AND; 110/0000000 OR; 100/0000000 XOR
  - 001/0000000 SLL; 101/0000000 SRL; 010/0000000 SLT
  - Any other combination (SLTU, SRA, or a nonzero funct7 elsewhere) is illegal.
- I-type ALU (opcode 0010011): reg_write=1, alu_src=1. funct7 is ignored except for shifts.
  - funct3 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT
  - funct3 001 SLL and 101 SRL require funct7=0000000; otherwise illegal.
  - funct3 011 (SLTIU) is illegal.
- Load (opcode 0000011, funct3 010, LW only): reg_write=1, alu_src=1, alu_ctrl=ADD, mem_read=1, mem_to_reg=1. Any other funct3 is illegal.
- Store (opcode 0100011, funct3 010, SW only): alu_src=1, alu_ctrl=ADD, mem_write=1, reg_write=0. Any other funct3 is illegal.
- Branch (opcode 1100011): alu_src=0, alu_ctrl=SUB, branch=1.
  - funct3 000 gives branch_ne=0 (BEQ); funct3 001 gives branch_ne=1 (BNE).
  - Any other funct3 is illegal.
- Illegal or unknown opcode: illegal=1 and all other outputs 0 (alu_ctrl=000). Because of this, an illegal instruction never asserts reg_write, mem_read or mem_write.
- At most one of mem_read, mem_write and branch is ever 1.
- X or Z on the inputs is not required to be handled; it is a don't-care.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with ADD on the inputs -> all outputs 0 at once, before any clock edge. Release rst_n, then one rising edge -> ADD decode appears.
- R-type: opcode 0110011, funct3 000.
  - funct7 0000000 -> after the next edge reg_write=1, alu_src=0, alu_ctrl=000.
  - funct7 0100000 -> reg_write=1, alu_src=0, alu_ctrl=001.
  - funct3 111/110/100/001/101/010 with funct7 0 -> alu_ctrl 010/011/100/101/110/111.
- ADDI: opcode 0010011, funct3 000, funct7 0000000, then repeat with funct7 0100000 -> both give reg_write=1, alu_src=1, alu_ctrl=000, illegal=0. SRLI with funct7 0100000 -> illegal=1.
- Memory: LW (0000011/010) -> reg_write=1, alu_src=1, mem_read=1, mem_to_reg=1, alu_ctrl=000. SW (0100011/010) -> mem_write=1, alu_src=1, reg_write=0.
- Branch: BEQ (1100011/000) -> branch=1, branch_ne=0, alu_ctrl=001, reg_write=0. BNE (1100011/001) -> branch_ne=1.
- Illegal and latency: opcode 1111111 -> illegal=1, all else 0. Change the inputs between edges -> outputs hold until the next rising edge.
